// File: rtl/pe_array_pkg.sv
// Shared types and default dimensions for the PE array feeder path.
package pe_array_pkg;

   localparam int PE_WIDTH = 16;
   localparam int PE_ROWS  = 4;
   localparam int PE_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } feeder_state_e;

   // One skew-lane slot at the default element width.
   typedef struct packed {
      logic                last;
      logic                valid;
      logic [PE_WIDTH-1:0] data;
   } lane_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register chain for one skew lane; advances only while enabled.
module skew_delay_line #(
   parameter int WIDTH = 16,
   parameter int DELAY = 1
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DELAY];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
      end else if (en_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DELAY-1];

endmodule

// File: rtl/feature_skew_feeder.sv
// Buffers feature vectors and feeds the PE array rows with a diagonal skew
// (row r lags row 0 by r cycles), inserting bubbles for gaps and hold.
module feature_skew_feeder
   import pe_array_pkg::*;
#(
   parameter int WIDTH = PE_WIDTH,
   parameter int ROWS  = PE_ROWS,
   parameter int DEPTH = PE_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [ROWS*WIDTH-1:0] s_data,
   input  logic                  s_last,
   input  logic                  hold,
   output logic [ROWS*WIDTH-1:0] feature_out,
   output logic [ROWS-1:0]       in_en,
   output logic                  busy,
   output logic                  done
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int DCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [ROWS*WIDTH:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   feeder_state_e         state_q, state_d;
   logic [DCNT_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic                  push, pop, fifo_empty;
   logic [ROWS*WIDTH-1:0] head_data;
   logic                  head_last;
   logic                  tail_last;

   assign s_ready    = (count_q < CNT_W'(DEPTH));
   assign push       = s_valid && s_ready;
   assign fifo_empty = (count_q == '0);
   assign {head_last, head_data} = mem_q[rd_ptr_q];
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
   assign busy       = (state_q != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_last, s_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         drain_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Pops happen only in STREAM so a following stream waits until the drain finishes.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      pop         = 1'b0;
      done        = 1'b0;
      case (state_q)
         IDLE: begin
            if (push || !fifo_empty) state_d = STREAM;
         end
         STREAM: begin
            if (!hold && !fifo_empty) begin
               pop = 1'b1;
               if (head_last) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            if (!hold) begin
               if (drain_cnt_q == DCNT_W'(ROWS-1)) begin
                  done    = tail_last;
                  state_d = IDLE;
               end else begin
                  drain_cnt_d = drain_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      // Only the last row needs to carry the last tag through its chain.
      localparam int LW = (r == ROWS-1) ? WIDTH + 2 : WIDTH + 1;
      logic [LW-1:0] lane_in, lane_out;

      assign lane_in = LW'({pop && head_last, pop,
                            pop ? head_data[r*WIDTH +: WIDTH] : {WIDTH{1'b0}}});

      skew_delay_line #(
         .WIDTH (LW),
         .DELAY (r + 1)
      ) u_dly (
         .clk   (clk),
         .clr_i (rst),
         .en_i  (!hold),
         .d_i   (lane_in),
         .q_o   (lane_out)
      );

      assign in_en[r] = !hold && lane_out[WIDTH];
      assign feature_out[r*WIDTH +: WIDTH] = in_en[r] ? lane_out[WIDTH-1:0] : {WIDTH{1'b0}};

      if (r == ROWS-1) begin : g_tail
         assign tail_last = lane_out[WIDTH+1];
      end
   end

endmodule
